// File: rtl/logic16_arbiter.sv
// Two-requester round-robin front end for a shared 16-bit bitwise logic unit.
// Results land in a single-entry response buffer with backpressure and a completion count.

module logic16_and (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign y[i] = a[i] & b[i];
    end
endmodule

module logic16_or (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign y[i] = a[i] | b[i];
    end
endmodule

module logic16_xor (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign y[i] = a[i] ^ b[i];
    end
endmodule

module logic16_not (
    input  logic [15:0] a,
    output logic [15:0] y
);
    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign y[i] = ~a[i];
    end
endmodule

module logic16_unit (
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic [15:0] y_and;
    logic [15:0] y_or;
    logic [15:0] y_xor;
    logic [15:0] y_not;

    logic16_and u_and (.a(a), .b(b), .y(y_and));
    logic16_or  u_or  (.a(a), .b(b), .y(y_or));
    logic16_xor u_xor (.a(a), .b(b), .y(y_xor));
    logic16_not u_not (.a(a), .y(y_not));

    always_comb begin
        y = y_and;
        unique case (op)
            2'b00: y = y_and;
            2'b01: y = y_or;
            2'b10: y = y_xor;
            2'b11: y = y_not;
        endcase
    end
endmodule

module logic16_rr_arb (
    input  logic valid0,
    input  logic valid1,
    input  logic rr_ptr,
    output logic gnt_valid,
    output logic gnt_id
);
    // rr_ptr only matters on contention; a lone requester always wins
    always_comb begin
        gnt_valid = valid0 | valid1;
        gnt_id    = 1'b0;
        unique case (1'b1)
            valid0 & valid1:  gnt_id = rr_ptr;
            ~valid0 & valid1: gnt_id = 1'b1;
            default:          gnt_id = 1'b0;
        endcase
    end
endmodule

module logic16_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid0,
    input  logic [1:0]  op0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    output logic        ready0,
    input  logic        valid1,
    input  logic [1:0]  op1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        ready1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_id,
    output logic [15:0] done_count
);
    logic        rr_ptr;
    logic        gnt_valid;
    logic        gnt_id;
    logic        can_accept;
    logic        accept;
    logic        drain;
    logic [1:0]  sel_op;
    logic [15:0] sel_a;
    logic [15:0] sel_b;
    logic [15:0] result;

    logic16_rr_arb u_arb (
        .valid0    (valid0),
        .valid1    (valid1),
        .rr_ptr    (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Buffer is free when empty or being drained this same cycle
    assign can_accept = ~rsp_valid | rsp_ready;
    assign accept     = gnt_valid & can_accept;
    assign drain      = rsp_valid & rsp_ready;
    assign ready0     = accept & ~gnt_id;
    assign ready1     = accept & gnt_id;

    assign sel_op = gnt_id ? op1 : op0;
    assign sel_a  = gnt_id ? a1 : a0;
    assign sel_b  = gnt_id ? b1 : b0;

    logic16_unit u_unit (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
            rsp_id    <= 1'b0;
            rr_ptr    <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= result;
            rsp_id    <= gnt_id;
            rr_ptr    <= ~gnt_id;
        end else if (drain) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_count <= 16'h0000;
        end else if (drain) begin
            done_count <= done_count + 16'h0001;
        end
    end
endmodule

// File: tb/tb_logic16_arbiter.sv
// Self-checking bench for logic16_arbiter: directed scenarios plus
// randomized traffic compared against a transaction-level reference model.

module tb_logic16_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        valid0, valid1;
    logic [1:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        ready0, ready1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic [15:0] done_count;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_id;
    logic        m_rr;
    logic [15:0] m_cnt;
    logic        m_acc0, m_acc1;

    logic [15:0] saved;

    always #5 clock = ~clock;

    logic16_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .valid0     (valid0),
        .op0        (op0),
        .a0         (a0),
        .b0         (b0),
        .ready0     (ready0),
        .valid1     (valid1),
        .op1        (op1),
        .a1         (a1),
        .b1         (b1),
        .ready1     (ready1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .done_count (done_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lop(input logic [1:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_id = 0; m_rr = 0; m_cnt = 0;
        m_acc0 = 1; m_acc1 = 1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, rsp_valid, 0);
        chk({tag, "_data"}, rsp_data, 16'h0000);
        chk({tag, "_id"}, rsp_id, 0);
        chk({tag, "_count"}, done_count, 16'h0000);
    endtask

    // Called just after a falling edge with inputs already applied
    task automatic step();
        logic gv, gid, ca, hs;
        #1;
        gv  = valid0 | valid1;
        gid = (valid0 && valid1) ? m_rr : valid1;
        ca  = !m_valid || rsp_ready;
        m_acc0 = gv && ca && !gid;
        m_acc1 = gv && ca && gid;
        chk("ready0", ready0, m_acc0);
        chk("ready1", ready1, m_acc1);
        @(posedge clock);
        hs = m_valid && rsp_ready;
        if (hs) m_cnt = m_cnt + 16'd1;
        if (m_acc0 || m_acc1) begin
            m_data  = gid ? lop(op1, a1, b1) : lop(op0, a0, b0);
            m_id    = gid;
            m_valid = 1;
            m_rr    = !gid;
        end else if (hs) begin
            m_valid = 0;
        end
        #1;
        chk("rsp_valid", rsp_valid, m_valid);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_id", rsp_id, m_id);
        chk("done_count", done_count, m_cnt);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        chk_reset_outputs("reset");
        @(negedge clock);
        reset = 0;
        model_reset();
    endtask

    initial begin
        valid0 = 0; valid1 = 0; op0 = 0; op1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; rsp_ready = 1;
        model_reset();
        do_reset();

        // single AND on requester 0
        valid0 = 1; op0 = 2'b00; a0 = 16'hF0F0; b0 = 16'h3C3C;
        step();
        chk("and0_data", rsp_data, 16'h3030);
        chk("and0_id", rsp_id, 0);
        valid0 = 0;
        step();
        chk("and0_count", done_count, 16'd1);

        // opcode sweep on requester 1
        begin
            logic [15:0] sweep [4];
            sweep[0] = 16'h0AA0; sweep[1] = 16'hAFFA;
            sweep[2] = 16'hA55A; sweep[3] = 16'h5555;
            valid1 = 1; a1 = 16'hAAAA; b1 = 16'h0FF0;
            for (int i = 0; i < 4; i++) begin
                op1 = 2'(i);
                step();
                chk("sweep_data", rsp_data, sweep[i]);
                chk("sweep_id", rsp_id, 1);
            end
            valid1 = 0;
            step();
        end

        // alternation under contention
        do_reset();
        valid0 = 1; valid1 = 1;
        op0 = 2'b01; a0 = 16'h1234; b0 = 16'h00FF;
        op1 = 2'b10; a1 = 16'hFFFF; b1 = 16'h5A5A;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_id", rsp_id, i % 2);
        end
        valid0 = 0; valid1 = 0;
        step();
        chk("rr_count", done_count, 16'd6);

        // backpressure with both valid and buffer full
        valid0 = 1; valid1 = 1;
        step();
        rsp_ready = 0;
        saved = rsp_data;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_frozen", rsp_data, saved);
        end
        rsp_ready = 1;
        #1;
        chk("bp_release_ready", ready0 | ready1, 1);
        step();
        chk("bp_still_valid", rsp_valid, 1);
        valid0 = 0; valid1 = 0;
        step();

        // done_count wrap
        do_reset();
        valid0 = 1; op0 = 2'b11; a0 = 16'h0F0F; b0 = 16'hFFFF;
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) step();
        chk("wrap_pre", done_count, 16'hFFFF);
        step();
        chk("wrap", done_count, 16'h0000);

        // reset while buffer full and a request pending
        rsp_ready = 0;
        step();
        #2;
        reset = 1;
        #1;
        chk_reset_outputs("midreset");
        chk("midreset_ready0", ready0, 1);
        chk("midreset_ready1", ready1, 0);
        @(negedge clock);
        reset = 0;
        model_reset();
        valid0 = 0;
        rsp_ready = 1;
        step();
        chk("midreset_gone", rsp_valid, 0);

        // randomized traffic honoring the hold-until-accepted rule
        for (int i = 0; i < 3000; i++) begin
            if (!(valid0 && !m_acc0)) begin
                valid0 = ($urandom_range(0, 2) != 0);
                op0 = 2'($urandom_range(0, 3));
                a0 = 16'($urandom); b0 = 16'($urandom);
            end
            if (!(valid1 && !m_acc1)) begin
                valid1 = ($urandom_range(0, 2) != 0);
                op1 = 2'($urandom_range(0, 3));
                a1 = 16'($urandom); b1 = 16'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/logic16_arbiter.md
# logic16_arbiter

Shares one 16-bit bitwise logic unit (AND/OR/XOR/NOT, built from the existing 16-bit gate arrays) between two requesters. Each requester presents operands and an opcode with a valid/ready handshake. A round-robin arbiter grants one requester per cycle. The result is registered into a single-entry response buffer with backpressure, and completed operations are counted. The block sits between the CPU-side register logic and a DMA/test requester that both need bitwise operations without duplicating the gate arrays.

## Interface
- No parameters; datapath width is fixed at 16 bits.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid0 / valid1  in  1  requester 0/1 has a request.
- op0 / op1  in  2  opcode: 00 AND, 01 OR, 10 XOR, 11 NOT a (b ignored).
- a0, b0 / a1, b1  in  16  operands of requester 0/1.
- ready0 / ready1  out  1  request accepted this cycle when validN & readyN.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer takes the result when rsp_valid & rsp_ready.
- rsp_data  out  16  result word.
- rsp_id  out  1  index of the requester that issued the result.
- done_count  out  16  number of completed response handshakes.

## Operation
- State: response buffer (rsp_valid, rsp_data, rsp_id), round-robin pointer rr_ptr (1 bit), done_count.
- can_accept = !rsp_valid | rsp_ready. This is a buffer that is empty or draining this cycle.
- Grant (combinational):
  - only valid0 → requester 0.
  - only valid1 → requester 1.
  - both → requester rr_ptr.
  - neither → none.
- readyN = can_accept & grant==N. At most one ready is high; ready never depends on the other requester's ready.
- Accept (valid & ready of granted N):
  - next edge: rsp_data ← op(aN, bN), rsp_id ← N, rsp_valid ← 1.
  - rr_ptr ← ~N.
- No accept: rr_ptr unchanged.
- Response handshake without accept: rsp_valid ← 0. rsp_data and rsp_id hold their last value.
- Response handshake: done_count ← done_count + 1, modulo 2^16 (0xFFFF wraps to 0x0000).
- Simultaneous response handshake and accept: the buffer is overwritten with the new result, rsp_valid stays 1, and done_count still increments.
- While rsp_valid & !rsp_ready: no accepts, and buffer contents are frozen.
  - Requesters must hold valid/op/operands stable until accepted.
  - The arbiter may re-grant on the next cycle from the current inputs.
- Opcode 11: result = ~a; b has no effect.

## Timing
- Reset (asynchronous, immediate):
  - rsp_valid=0, rsp_data=0x0000, rsp_id=0, rr_ptr=0, done_count=0x0000.
  - ready0/ready1 follow combinationally (high for a valid requester after reset, since the buffer is empty).
- Reset asserted mid-transaction: a buffered result is discarded and not counted. A request accepted in the same cycle as the reset edge is lost.
- Latency: accept at edge k → rsp_valid=1 with the result after edge k.
- Throughput: one result per cycle while rsp_ready stays high. The two requesters alternate when both are continuously valid.
- No combinational path from rsp_data to any input. The only combinational input-to-output paths are validN/rsp_ready → ready0/ready1.

## Test plan
- Reset, then valid0=1, op0=00, a0=0xF0F0, b0=0x3C3C, rsp_ready=1 → ready0=1; next cycle rsp_valid=1, rsp_data=0x3030, rsp_id=0, done_count=1 after the following edge.
- Opcode sweep on requester 1 with a1=0xAAAA, b1=0x0FF0 → results AND=0x0AA0, OR=0xAFFA, XOR=0xA55A, NOT=0x5555, all with rsp_id=1.
- Both valid continuously, rsp_ready=1, 6 cycles → grants 0,1,0,1,0,1; rsp_id sequence matches; done_count=6.
- rsp_ready=0 for 3 cycles with both valid and the buffer full → ready0=ready1=0, and rsp_data stays constant. Raising rsp_ready → accept and drain occur in the same cycle, rsp_valid stays 1, and the new data appears on the next cycle.
- Preload done_count to 0xFFFF via 65535 handshakes (or force), then one more handshake → done_count=0x0000.
- Assert reset while rsp_valid=1 and valid0=1 → all outputs return to their reset values immediately, and the buffered result is never presented.
